// File: rtl/count4down_load.sv
// -----------------------------------------------------------------------------
// count4down_load
//
// Loadable, programmable down counter used as an interval timer. A start
// value is loaded, the counter decrements on enabled cycles while running, and
// a one-cycle terminal-count pulse (tc) is produced when the count expires.
// Two modes are selected by 'reload' at the moment of expiry:
//   - one-shot   : q settles at 0, busy drops, done is set (sticky until load)
//   - auto-reload: q is reloaded from the last loaded value, counter keeps RUN
// Everything is synchronous to clk; there is no ripple clocking.
//
// Optional build macro: COUNT4DOWN_PRESCALE_EN
//   When defined, parameter PRESCALE is added and a decrement only happens on
//   every PRESCALE-th enabled cycle in RUN. When undefined, every enabled
//   cycle in RUN decrements and no prescaler hardware exists.
//
// Parameters:
//   WIDTH    - counter width in bits (2..16)
//   PRESCALE - enabled cycles per decrement (2..256), macro builds only
//
// Ports:
//   clk    in   clock, all state changes on the rising edge
//   clr    in   asynchronous active-low reset
//   load   in   synchronous load strobe (priority over en in every state)
//   d      in   load / reload value
//   en     in   count enable
//   reload in   1 = auto-reload at terminal count, 0 = one-shot
//   q      out  current count
//   qb     out  bitwise complement of q
//   tc     out  registered one-cycle terminal-count pulse
//   busy   out  high while counting (RUN)
//   done   out  one-shot completion flag, cleared by any load
// -----------------------------------------------------------------------------
module count4down_load #(
   parameter int WIDTH = 4
`ifdef COUNT4DOWN_PRESCALE_EN
   ,
   parameter int PRESCALE = 2
`endif
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   input  logic             reload,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] rv_q, rv_d;
   logic             tc_q, tc_d;

   // ps_tick marks an enabled RUN cycle that is allowed to decrement.
   logic             ps_tick;

`ifdef COUNT4DOWN_PRESCALE_EN
   localparam int              PS_W    = $clog2(PRESCALE);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] ps_q, ps_d;

   assign ps_tick = (ps_q == PS_LAST);

   // The prescaler only advances on enabled RUN cycles. It restarts on load,
   // and wraps to zero on the decrementing cycle, which also covers the
   // transition into DONE so a later run starts from a clean phase.
   always_comb begin
      ps_d = ps_q;
      if (load) begin
         ps_d = '0;
      end else if ((state_q == ST_RUN) && en) begin
         if (ps_tick) begin
            ps_d = '0;
         end else begin
            ps_d = ps_q + PS_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         ps_q <= '0;
      end else begin
         ps_q <= ps_d;
      end
   end
`else
   assign ps_tick = 1'b1;
`endif

   // Next-state logic. Load wins over everything; a load coinciding with a
   // terminal count therefore restarts the counter and leaves tc low.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      rv_d    = rv_q;
      tc_d    = 1'b0;

      if (load) begin
         count_d = d;
         rv_d    = d;
         // A zero load cannot produce any interval, so it parks in IDLE.
         state_d = (d != '0) ? ST_RUN : ST_IDLE;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (en && ps_tick) begin
                  if (count_q == ONE) begin
                     // Expiry: 'reload' is only looked at here.
                     tc_d = 1'b1;
                     if (reload) begin
                        count_d = rv_q;
                     end else begin
                        count_d = '0;
                        state_d = ST_DONE;
                     end
                  end else begin
                     // count_q is never 0 in RUN, so this never wraps.
                     count_d = count_q - ONE;
                  end
               end
            end
            ST_DONE: begin
               count_d = '0;
            end
            default: begin
               // IDLE holds its value until the next load.
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         rv_q    <= '0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rv_q    <= rv_d;
         tc_q    <= tc_d;
      end
   end

   assign q    = count_q;
   assign tc   = tc_q;
   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_qb
         assign qb[gi] = ~count_q[gi];
      end
   endgenerate

endmodule

// File: tb/tb_count4down_load.sv
// -----------------------------------------------------------------------------
// tb_count4down_load
//
// Scenario tasks drive count4down_load (WIDTH=4) and compare its outputs with
// a behavioural timer model: a remaining-count integer, a saved period, a
// running/finished flag pair and an enabled-cycle tally for the prescaler.
// Works with and without COUNT4DOWN_PRESCALE_EN defined.
// -----------------------------------------------------------------------------
module tb_count4down_load;

   localparam int W = 4;
`ifdef COUNT4DOWN_PRESCALE_EN
   localparam int PS = 2;
`else
   localparam int PS = 1;
`endif

   logic         clk = 1'b0;
   logic         clr;
   logic         load;
   logic [W-1:0] d;
   logic         en;
   logic         reload;
   logic [W-1:0] q;
   logic [W-1:0] qb;
   logic         tc;
   logic         busy;
   logic         done;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   int m_q;
   int m_rv;
   int m_pre;
   bit m_busy;
   bit m_done;
   bit m_tc;

   count4down_load #(.WIDTH(W)) dut (
      .clk    (clk),
      .clr    (clr),
      .load   (load),
      .d      (d),
      .en     (en),
      .reload (reload),
      .q      (q),
      .qb     (qb),
      .tc     (tc),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      m_q    = 0;
      m_rv   = 0;
      m_pre  = 0;
      m_busy = 0;
      m_done = 0;
      m_tc   = 0;
   endfunction

   // One rising edge of the timer: a load restarts the interval; otherwise an
   // enabled running cycle counts toward the next decrement, and a remaining
   // count reaching zero is the terminal event.
   function automatic void model_step(bit l, int dv, bit e, bit r);
      m_tc = 0;
      if (l) begin
         m_q    = dv;
         m_rv   = dv;
         m_busy = (dv != 0);
         m_done = 0;
         m_pre  = 0;
      end else if (m_busy && e) begin
         m_pre = m_pre + 1;
         if (m_pre == PS) begin
            m_pre = 0;
            m_q   = m_q - 1;
            if (m_q == 0) begin
               m_tc = 1;
               if (r) begin
                  m_q = m_rv;
               end else begin
                  m_busy = 0;
                  m_done = 1;
               end
            end
         end
      end
   endfunction

   // Apply inputs at the falling edge, step the model on the rising edge and
   // return at the next falling edge, ready for sampling.
   task automatic cyc(input bit l, input int dv, input bit e, input bit r);
      load   = l;
      d      = W'(dv);
      en     = e;
      reload = r;
      @(posedge clk);
      model_step(l, dv, e, r);
      @(negedge clk);
      $display("[TB] t=%0t load=%0b d=%0d en=%0b reload=%0b -> q=%0d qb=%0h tc=%0b busy=%0b done=%0b",
               $time, l, dv, e, r, q, qb, tc, busy, done);
   endtask

   task automatic test_reset();
      clr = 1'b0; load = 1'b0; d = '0; en = 1'b0; reload = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if ({q, qb, tc, busy, done} !== {4'd0, 4'hF, 3'b000}) begin
         n_fail++;
         $display("FAIL reset_init: got q=%0d qb=%0h tc=%0b busy=%0b done=%0b, want q=0 qb=f tc=0 busy=0 done=0",
                  q, qb, tc, busy, done);
      end
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);

      cyc(1, 9, 0, 0);
      repeat (3) cyc(0, 0, 1, 0);
      n_tests++;
      if (q !== 4'd6 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_precount: got q=%0d busy=%0b, want q=6 busy=1", q, busy);
      end

      en = 1'b0;
      #1 clr = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if ({q, qb, tc, busy, done} !== {4'd0, 4'hF, 3'b000}) begin
         n_fail++;
         $display("FAIL reset_async: got q=%0d qb=%0h tc=%0b busy=%0b done=%0b, want q=0 qb=f tc=0 busy=0 done=0",
                  q, qb, tc, busy, done);
      end
      #1 clr = 1'b1;
      @(negedge clk);
      repeat (2) cyc(0, 0, 1, 0);
      n_tests++;
      if (q !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_after: got q=%0d busy=%0b tc=%0b, want q=0 busy=0 tc=0", q, busy, tc);
      end
   endtask

   task automatic test_oneshot();
      int tcs;
      tcs = 0;
      cyc(1, 3, 0, 0);
      n_tests++;
      if (q !== 4'd3 || busy !== 1'b1 || tc !== 1'b0) begin
         n_fail++;
         $display("FAIL oneshot_load: got q=%0d busy=%0b tc=%0b, want q=3 busy=1 tc=0", q, busy, tc);
      end
      for (int i = 0; i < 3 * PS + 4; i++) begin
         cyc(0, 0, 1, 0);
         n_tests++;
         if ({q, tc, busy, done} !== {W'(m_q), m_tc, m_busy, m_done}) begin
            n_fail++;
            $display("FAIL oneshot_step%0d: got q=%0d tc=%0b busy=%0b done=%0b, want q=%0d tc=%0b busy=%0b done=%0b",
                     i, q, tc, busy, done, m_q, m_tc, m_busy, m_done);
         end
         tcs += int'(tc);
      end
      n_tests++;
      if (tcs != 1 || done !== 1'b1 || q !== 4'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL oneshot_end: got tc_pulses=%0d done=%0b q=%0d busy=%0b, want 1 1 0 0", tcs, done, q, busy);
      end
   endtask

   task automatic test_autoreload();
      int tcs;
      tcs = 0;
      cyc(1, 4, 0, 1);
      for (int i = 0; i < 12 * PS; i++) begin
         cyc(0, 0, 1, 1);
         n_tests++;
         if ({q, tc, busy, done} !== {W'(m_q), m_tc, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL autoreload_step%0d: got q=%0d tc=%0b busy=%0b done=%0b, want q=%0d tc=%0b busy=1 done=0",
                     i, q, tc, busy, done, m_q, m_tc);
         end
         tcs += int'(tc);
      end
      n_tests++;
      if (tcs != 3) begin
         n_fail++;
         $display("FAIL autoreload_pulses: got %0d tc pulses, want 3", tcs);
      end
   endtask

   task automatic test_en_gaps();
      int ens;
      int tc_at;
      ens = 0;
      tc_at = -1;
      cyc(1, 15, 0, 0);
      for (int i = 0; i < 30 * PS + 6; i++) begin
         bit e;
         e = (i % 2 == 0);
         cyc(0, 0, e, 0);
         if (e) ens++;
         n_tests++;
         if (q !== W'(m_q) || qb !== ~q || tc !== m_tc) begin
            n_fail++;
            $display("FAIL engap_step%0d: got q=%0d qb=%0h tc=%0b, want q=%0d qb=%0h tc=%0b",
                     i, q, qb, tc, m_q, ~W'(m_q), m_tc);
         end
         if (tc === 1'b1 && tc_at < 0) tc_at = ens;
      end
      n_tests++;
      if (tc_at != 15 * PS) begin
         n_fail++;
         $display("FAIL engap_tc_count: got tc after %0d enabled cycles, want %0d", tc_at, 15 * PS);
      end
   endtask

   task automatic test_load_collision();
      int ens;
      int tc_at;
      cyc(1, 3, 0, 1);
      for (int i = 0; i < 40 && !(m_q == 1 && m_pre == PS - 1); i++) cyc(0, 0, 1, 1);
      cyc(1, 7, 1, 1);
      n_tests++;
      if (q !== 4'd7 || tc !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL collide_load: got q=%0d tc=%0b busy=%0b, want q=7 tc=0 busy=1", q, tc, busy);
      end
      ens = 0;
      tc_at = -1;
      for (int i = 0; i < 8 * PS && tc_at < 0; i++) begin
         cyc(0, 0, 1, 1);
         ens++;
         if (tc === 1'b1) tc_at = ens;
      end
      n_tests++;
      if (tc_at != 7 * PS || q !== 4'd7) begin
         n_fail++;
         $display("FAIL collide_period: got tc after %0d cycles q=%0d, want %0d cycles q=7", tc_at, q, 7 * PS);
      end

      cyc(1, 1, 0, 0);
      repeat (PS) cyc(0, 0, 1, 0);
      n_tests++;
      if (done !== 1'b1 || q !== 4'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL collide_todone: got done=%0b q=%0d busy=%0b, want 1 0 0", done, q, busy);
      end
      cyc(1, 0, 1, 0);
      n_tests++;
      if ({q, tc, busy, done} !== {4'd0, 3'b000}) begin
         n_fail++;
         $display("FAIL collide_load0: got q=%0d tc=%0b busy=%0b done=%0b, want q=0 tc=0 busy=0 done=0",
                  q, tc, busy, done);
      end
      cyc(0, 0, 1, 0);
      n_tests++;
      if ({q, tc, busy, done} !== {4'd0, 3'b000}) begin
         n_fail++;
         $display("FAIL collide_idle: got q=%0d tc=%0b busy=%0b done=%0b, want all 0", q, tc, busy, done);
      end
   endtask

   task automatic test_prescale();
      int tc_at;
      tc_at = -1;
      cyc(1, 2, 0, 0);
      for (int i = 1; i <= 10 && tc_at < 0; i++) begin
         cyc(0, 0, 1, 0);
         n_tests++;
         if (q !== W'(m_q) || tc !== m_tc) begin
            n_fail++;
            $display("FAIL prescale_step%0d: got q=%0d tc=%0b, want q=%0d tc=%0b", i, q, tc, m_q, m_tc);
         end
         if (tc === 1'b1) tc_at = i;
      end
      n_tests++;
      if (tc_at != 2 * PS) begin
         n_fail++;
         $display("FAIL prescale_tc: got tc on enabled cycle %0d, want %0d", tc_at, 2 * PS);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         bit l;
         bit e;
         bit r;
         int dv;
         l  = ($urandom_range(0, 9) == 0);
         dv = int'($urandom_range(0, 15));
         e  = ($urandom_range(0, 3) != 0);
         r  = 1'($urandom_range(0, 1));
         cyc(l, dv, e, r);
         n_tests++;
         if ({q, qb, tc, busy, done} !== {W'(m_q), ~W'(m_q), m_tc, m_busy, m_done}) begin
            n_fail++;
            $display("FAIL random_step%0d: got q=%0d qb=%0h tc=%0b busy=%0b done=%0b, want q=%0d tc=%0b busy=%0b done=%0b",
                     i, q, qb, tc, busy, done, m_q, m_tc, m_busy, m_done);
         end
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_autoreload();
      test_en_gaps();
      test_load_collision();
      test_prescale();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
